// File: rtl/ddr5_phy_crc_pkg.sv
// ddr5_phy_crc_pkg: shared FSM state type and sizing constants for the read-CRC sequencer.
package ddr5_phy_crc_pkg;
  typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;
  localparam int BEAT_W = 4;
  localparam int DEF_DATA_BEATS = 8;
  localparam int DEF_ALERT_W = 4;
endpackage

// File: rtl/ddr5_phy_crc_alert_stretch.sv
// ddr5_phy_crc_alert_stretch: load/reload down-counter that holds the active-low alert for pALERT_W cycles.
module ddr5_phy_crc_alert_stretch #(
  parameter int pALERT_W = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load_i,
  output logic alert_n_o
);
  localparam int CW = $clog2(pALERT_W + 1);
  logic [CW-1:0] cnt;
  // a reload while already low restarts the full width, so back-to-back errors extend the pulse
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt <= '0;
    else if (load_i) cnt <= CW'(pALERT_W);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign alert_n_o = (cnt == '0);
endmodule

// File: rtl/ddr5_phy_crc_rd_ctrl.sv
// ddr5_phy_crc_rd_ctrl: read-burst CRC sequencer driving generator/checker strobes, alert, error counting.
// Define DDR5_CRC_ERR_LOG_EN to add the first-failing-burst id log.
module ddr5_phy_crc_rd_ctrl
  import ddr5_phy_crc_pkg::*;
#(
  parameter int pDATA_BEATS = DEF_DATA_BEATS,
  parameter int pALERT_W    = DEF_ALERT_W,
  parameter int pCNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cfg_crc_en_i,
  input  logic              burst_start_i,
  input  logic              crc_match_i,
  input  logic              clr_i,
  output logic              crc_clr_o,
  output logic              crc_gen_en_o,
  output logic              crc_cmp_o,
  output logic              dfi_alert_n_o,
  output logic              busy_o,
  output logic [pCNT_W-1:0] err_cnt_o,
  output logic              proto_err_o
`ifdef DDR5_CRC_ERR_LOG_EN
  ,
  output logic [pCNT_W-1:0] err_first_id_o,
  output logic              err_first_vld_o
`endif
);
  state_t state, state_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_nxt;
  logic start_acc, last_beat, mismatch;
  always_comb begin
    start_acc = burst_start_i & cfg_crc_en_i & (state != DATA);
    last_beat = (beat_cnt == BEAT_W'(pDATA_BEATS - 1));
    state_nxt = start_acc ? DATA : (state == DATA) ? (last_beat ? CRC : DATA) : IDLE;
    beat_nxt  = start_acc ? BEAT_W'(1) : (state == DATA) ? beat_cnt + 1'b1 : '0;
    mismatch  = (state == CRC) & ~crc_match_i;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
    end
  // beat 0 is the start cycle itself, so strobes and busy include the accepted start combinationally
  assign crc_clr_o    = start_acc;
  assign crc_gen_en_o = start_acc | (state == DATA);
  assign crc_cmp_o    = (state == CRC);
  assign busy_o       = start_acc | (state != IDLE);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      err_cnt_o   <= '0;
      proto_err_o <= 1'b0;
    end else if (clr_i) begin
      err_cnt_o   <= '0;
      proto_err_o <= 1'b0;
    end else begin
      if (mismatch && !(&err_cnt_o)) err_cnt_o <= err_cnt_o + 1'b1;
      if (state == DATA && burst_start_i) proto_err_o <= 1'b1;
    end
  ddr5_phy_crc_alert_stretch #(.pALERT_W(pALERT_W)) u_alert (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .load_i   (mismatch),
    .alert_n_o(dfi_alert_n_o)
  );
`ifdef DDR5_CRC_ERR_LOG_EN
  logic [pCNT_W-1:0] burst_id;
  // burst_id advances at the accepted start, so during a burst it holds that burst's 1-based id
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      burst_id        <= '0;
      err_first_id_o  <= '0;
      err_first_vld_o <= 1'b0;
    end else begin
      if (start_acc) burst_id <= burst_id + 1'b1;
      if (clr_i) begin
        err_first_id_o  <= '0;
        err_first_vld_o <= 1'b0;
      end else if (mismatch && !err_first_vld_o) begin
        err_first_id_o  <= burst_id;
        err_first_vld_o <= 1'b1;
      end
    end
`endif
endmodule

// File: tb/tb_ddr5_phy_crc_rd_ctrl.sv
// tb_ddr5_phy_crc_rd_ctrl: table-driven directed bench for the read-CRC sequencer (pCNT_W=4).
module tb_ddr5_phy_crc_rd_ctrl;
  logic clk = 1'b0;
  logic rst_n, cfg, start, match, clr;
  logic crc_clr, gen, cmp, alert_n, busy, proto;
  logic [3:0] err;

  always #5 clk = ~clk;

  ddr5_phy_crc_rd_ctrl #(.pDATA_BEATS(8), .pALERT_W(4), .pCNT_W(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_crc_en_i(cfg), .burst_start_i(start),
    .crc_match_i(match), .clr_i(clr), .crc_clr_o(crc_clr), .crc_gen_en_o(gen),
    .crc_cmp_o(cmp), .dfi_alert_n_o(alert_n), .busy_o(busy), .err_cnt_o(err),
    .proto_err_o(proto)
  );

  typedef struct packed {
    logic       s, c, m, k;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl[$];
  int errors = 0, checks = 0;
  localparam logic [9:0] RST_VEC = 10'b0001000000;

  function automatic logic [9:0] act();
    return {crc_clr, gen, cmp, alert_n, busy, proto, err};
  endfunction

  task automatic chk(input string name, input logic [9:0] a, input logic [9:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%b want=%b (clr,gen,cmp,alert_n,busy,proto,err[3:0])", name, a, e);
    end
  endtask

  task automatic add(input logic s, c, m, k, cl, g, cp, a, b, p, input logic [3:0] e);
    tbl.push_back({s, c, m, k, cl, g, cp, a, b, p, e});
  endtask

  task automatic cyc(input logic s, c, m, k);
    @(negedge clk);
    start = s; cfg = c; match = m; clr = k;
    #1;
  endtask

  initial begin
    // single passing burst; match low on data beats must not count
    add(1,1,0,0, 1,1,0,1,1,0,4'd0);
    for (int i = 1; i < 8; i++) add(0,1,0,0, 0,1,0,1,1,0,4'd0);
    add(0,1,1,0, 0,0,1,1,1,0,4'd0);
    add(0,1,0,0, 0,0,0,1,0,0,4'd0);
    // single failing burst: 4-cycle alert starting beat 9
    add(1,1,1,0, 1,1,0,1,1,0,4'd0);
    for (int i = 1; i < 8; i++) add(0,1,1,0, 0,1,0,1,1,0,4'd0);
    add(0,1,0,0, 0,0,1,1,1,0,4'd0);
    for (int i = 0; i < 4; i++) add(0,1,1,0, 0,0,0,0,0,0,4'd1);
    add(0,1,1,0, 0,0,0,1,0,0,4'd1);
    // start at beat 3: proto error, burst unchanged; clr clears sticky flag and counter
    add(1,1,1,0, 1,1,0,1,1,0,4'd1);
    for (int i = 1; i < 3; i++) add(0,1,1,0, 0,1,0,1,1,0,4'd1);
    add(1,1,1,0, 0,1,0,1,1,0,4'd1);
    for (int i = 4; i < 8; i++) add(0,1,1,0, 0,1,0,1,1,1,4'd1);
    add(0,1,1,0, 0,0,1,1,1,1,4'd1);
    add(0,1,1,1, 0,0,0,1,0,1,4'd1);
    add(0,1,1,0, 0,0,0,1,0,0,4'd0);
    // disabled start ignored; enable dropped mid-burst has no effect; clr leaves alert running
    add(1,0,0,0, 0,0,0,1,0,0,4'd0);
    add(1,1,1,0, 1,1,0,1,1,0,4'd0);
    for (int i = 1; i < 4; i++) add(0,1,1,0, 0,1,0,1,1,0,4'd0);
    for (int i = 4; i < 8; i++) add(0,0,1,0, 0,1,0,1,1,0,4'd0);
    add(0,0,0,0, 0,0,1,1,1,0,4'd0);
    add(0,0,1,0, 0,0,0,0,0,0,4'd1);
    add(0,0,1,1, 0,0,0,0,0,0,4'd1);
    for (int i = 0; i < 2; i++) add(0,0,1,0, 0,0,0,0,0,0,4'd0);
    add(0,1,1,0, 0,0,0,1,0,0,4'd0);
    // clr on a failing CRC beat wins over the increment but the alert still fires
    add(1,1,1,0, 1,1,0,1,1,0,4'd0);
    for (int i = 1; i < 8; i++) add(0,1,1,0, 0,1,0,1,1,0,4'd0);
    add(0,1,0,1, 0,0,1,1,1,0,4'd0);
    for (int i = 0; i < 4; i++) add(0,1,1,0, 0,0,0,0,0,0,4'd0);
    add(0,1,1,0, 0,0,0,1,0,0,4'd0);

    rst_n = 1'b0; cfg = 1'b1; start = 1'b0; match = 1'b1; clr = 1'b0;
    #2 chk("reset", act(), RST_VEC);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].s, tbl[i].c, tbl[i].m, tbl[i].k);
      chk($sformatf("vec%0d", i), act(), tbl[i].exp);
    end

    // back-to-back failing bursts starting at cycles 0 and 9
    for (int c = 0; c < 23; c++) begin
      logic g, p, a;
      cyc(c == 0 || c == 9, 1'b1, 1'b0, 1'b0);
      g = (c < 18) && c != 8 && c != 17;
      p = (c == 8) || (c == 17);
      a = !((c >= 9 && c <= 12) || (c >= 18 && c <= 21));
      chk($sformatf("b2b_c%0d", c), {7'b0, gen, cmp, alert_n}, {7'b0, g, p, a});
    end
    chk("b2b_err", {6'b0, err}, 10'd2);

    // saturation of the 4-bit error counter
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    for (int b = 0; b < 17; b++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i < 8; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      if (b == 0) chk("sat_b1", {6'b0, err}, 10'd1);
      if (b == 14) chk("sat_b15", {6'b0, err}, 10'd15);
    end
    chk("sat_b17", {6'b0, err}, 10'd15);

    // asynchronous reset at beat 5 of a burst
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("pre_rst_busy", {9'b0, busy}, 10'd1);
    rst_n = 1'b0;
    #1 chk("async_rst", act(), RST_VEC);
    @(negedge clk) rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("post_rst_idle", act(), RST_VEC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
